led_blink_ctrl: RTL and testbench

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

---
 rtl/led_blink_pkg.sv | 7 +
 rtl/led_chan.sv | 76 +++++++
 rtl/led_blink_ctrl.sv | 45 ++++
 tb/tb_led_blink_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared mode enum and field widths for led_blink_ctrl and led_chan
package led_blink_pkg;
  localparam int MODE_W = 3;
  localparam int BURST_W = 8;
  localparam int PWM_W = 8;
  typedef enum logic [MODE_W-1:0] {OFF, ON, BLINK, BURST, BREATHE} mode_e;
endpackage

// File: rtl/led_chan.sv
// led_chan: one LED channel FSM (ports clk, reset_, tick, cfg_we/cfg_mode/cfg_count in, led/busy out); BREATHE PWM only with LED_BREATHE_EN
module led_chan
  import led_blink_pkg::*;
(
  input  logic               clk,
  input  logic               reset_,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [MODE_W-1:0]  cfg_mode,
  input  logic [BURST_W-1:0] cfg_count,
  output logic               led,
  output logic               busy
);
  mode_e mode_q, mode_d, req_mode;
  logic led_q, led_d, bre;
  logic [BURST_W-1:0] cnt_q, cnt_d;
`ifdef LED_BREATHE_EN
  assign bre = cfg_mode == 3'd4;
`else
  assign bre = 1'b0;
`endif
  assign req_mode = cfg_mode == 3'd1 ? ON :
                    cfg_mode == 3'd2 ? BLINK :
                    (cfg_mode == 3'd3 && |cfg_count) ? BURST :
                    bre ? BREATHE : OFF;
  assign busy = mode_q == BURST;
  always_comb begin
    mode_d = mode_q;
    led_d = led_q;
    cnt_d = cnt_q;
    if (cfg_we) begin
      mode_d = req_mode;
      led_d = req_mode inside {ON, BLINK, BURST};
      cnt_d = req_mode == BURST ? cfg_count : '0;
    end else if (tick && mode_q == BLINK) begin
      led_d = !led_q;
    end else if (tick && mode_q == BURST) begin
      led_d = !led_q && cnt_q != '0;
      cnt_d = (led_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      mode_d = (!led_q && cnt_q == '0) ? OFF : BURST;
    end
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      mode_q <= OFF;
      led_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] phase_q, phase_d, duty_q, duty_d;
  logic up_q, up_d, turn;
  assign turn = up_q ? &duty_q : ~|duty_q;
  always_comb begin
    phase_d = phase_q + 1'b1;
    up_d = cfg_we ? 1'b1 : (tick && mode_q == BREATHE) ? up_q ^ turn : up_q;
    duty_d = cfg_we ? '0 : (tick && mode_q == BREATHE) ? ((up_q ^ turn) ? duty_q + 1'b1 : duty_q - 1'b1) : duty_q;
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      phase_q <= '0;
      duty_q <= '0;
      up_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      duty_q <= duty_d;
      up_q <= up_d;
    end
  assign led = mode_q == BREATHE ? phase_q < duty_q : led_q;
`else
  assign led = led_q;
`endif
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED blink controller (ports clk, reset_, cfg_valid/cfg_ready/cfg_chan/cfg_mode/cfg_count, led, busy); LED_BREATHE_EN enables BREATHE
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int               NUM_LEDS = 4,
  parameter int               CNT_W    = 22,
  parameter logic [CNT_W-1:0] TICK_DIV = 22'd3993608,
  localparam int              CH_W     = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [BURST_W-1:0]  cfg_count,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy
);
  localparam int BP_W = 1 << CH_W;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [BP_W-1:0] busy_pad;
  logic tick, acc;
  assign tick = pre_q == TICK_DIV;
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  // Channels past NUM_LEDS read as never busy, so they are accepted and dropped.
  assign busy_pad = BP_W'(busy);
  assign cfg_ready = !busy_pad[cfg_chan];
  assign acc = cfg_valid && cfg_ready;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) pre_q <= '0;
    else pre_q <= pre_d;
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_chan u_chan (
      .clk       (clk),
      .reset_    (reset_),
      .tick      (tick),
      .cfg_we    (acc && cfg_chan == CH_W'(i)),
      .cfg_mode  (cfg_mode),
      .cfg_count (cfg_count),
      .led       (led[i]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed self-checking bench for led_blink_ctrl with TICK_DIV=3
module tb_led_blink_ctrl;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [2:0] cfg_mode = '0;
  logic [7:0] cfg_count = '0;
  logic [3:0] led, busy;
  logic c3_valid = 1'b0;
  logic c3_ready;
  logic [1:0] c3_chan = '0;
  logic [2:0] c3_mode = '0;
  logic [7:0] c3_count = '0;
  logic [2:0] c3_led, c3_busy;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always #5 clk = !clk;
  always @(posedge clk or negedge reset_)
    if (!reset_) cyc <= 0;
    else cyc <= cyc + 1;
  led_blink_ctrl #(.NUM_LEDS(4), .CNT_W(22), .TICK_DIV(22'd3)) u_dut (
    .clk(clk), .reset_(reset_), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_count(cfg_count), .led(led), .busy(busy));
  led_blink_ctrl #(.NUM_LEDS(3), .CNT_W(22), .TICK_DIV(22'd3)) u_dut3 (
    .clk(clk), .reset_(reset_), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
    .cfg_chan(c3_chan), .cfg_mode(c3_mode), .cfg_count(c3_count), .led(c3_led), .busy(c3_busy));
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Moves to a cycle in which the prescaler is at its terminal count.
  task automatic align();
    while (cyc % 4 != 3) step(1);
  endtask
  task automatic cfg(input logic [1:0] ch, input logic [2:0] m, input logic [7:0] n);
    cfg_chan = ch;
    cfg_mode = m;
    cfg_count = n;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    checks++; if (led !== 4'b0) begin errors++; $display("FAIL reset_hold led=%b exp=0000", led); end
    @(negedge clk) reset_ = 1'b1;
    #1;
    checks++; if (led !== 4'b0 || busy !== 4'b0) begin errors++; $display("FAIL reset_rel led=%b busy=%b exp=0000/0000", led, busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    step(6);
    checks++; if (led !== 4'b0 || busy !== 4'b0) begin errors++; $display("FAIL reset_idle led=%b busy=%b exp=0000/0000", led, busy); end
  endtask
  task automatic test_on_blink();
    align();
    cfg(2'd1, 3'd1, 8'd0);
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL on_led1 got=%b exp=1", led[1]); end
    align();
    cfg(2'd2, 3'd2, 8'd0);
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL blink_accept got=%b exp=1", led[2]); end
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if (led[2] !== ((k / 4) % 2 == 0)) begin errors++; $display("FAIL blink_k%0d got=%b exp=%b", k, led[2], (k / 4) % 2 == 0); end
    end
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL on_hold got=%b exp=1", led[1]); end
  endtask
  task automatic test_burst();
    logic el, eb;
    align();
    cfg(2'd0, 3'd3, 8'd3);
    for (int k = 0; k < 28; k++) begin
      el = (k / 4 < 5) && ((k / 4) % 2 == 0);
      eb = k / 4 < 6;
      checks++; if (led[0] !== el) begin errors++; $display("FAIL burst_led_k%0d got=%b exp=%b", k, led[0], el); end
      checks++; if (busy[0] !== eb) begin errors++; $display("FAIL burst_busy_k%0d got=%b exp=%b", k, busy[0], eb); end
      if (k == 6) begin
        cfg_chan = 2'd0;
        cfg_mode = 3'd1;
        cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL burst_block got=%b exp=0", cfg_ready); end
        cfg_chan = 2'd1;
        cfg_mode = 3'd0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL burst_other_ready got=%b exp=1", cfg_ready); end
      end
      step(1);
      cfg_valid = 1'b0;
      if (k == 6) begin
        checks++; if (led[1] !== 1'b0) begin errors++; $display("FAIL burst_other_led got=%b exp=0", led[1]); end
      end
    end
  endtask
  task automatic test_off_cases();
    cfg(2'd3, 3'd1, 8'd0);
    checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL on_led3 got=%b exp=1", led[3]); end
    cfg(2'd3, 3'd3, 8'd0);
    checks++; if (led[3] !== 1'b0 || busy[3] !== 1'b0) begin errors++; $display("FAIL burst0 led=%b busy=%b exp=0/0", led[3], busy[3]); end
    cfg(2'd3, 3'd1, 8'd0);
    cfg(2'd3, 3'd6, 8'd0);
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL mode6 got=%b exp=0", led[3]); end
`ifndef LED_BREATHE_EN
    cfg(2'd3, 3'd1, 8'd0);
    cfg(2'd3, 3'd4, 8'd0);
    step(8);
    checks++; if (led[3] !== 1'b0 || busy[3] !== 1'b0) begin errors++; $display("FAIL mode4_off led=%b busy=%b exp=0/0", led[3], busy[3]); end
`endif
    c3_chan = 2'd0;
    c3_mode = 3'd1;
    c3_valid = 1'b1;
    step(1);
    checks++; if (c3_led !== 3'b001) begin errors++; $display("FAIL oor_pre got=%b exp=001", c3_led); end
    c3_chan = 2'd3;
    c3_mode = 3'd0;
    #1;
    checks++; if (c3_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got=%b exp=1", c3_ready); end
    step(1);
    c3_valid = 1'b0;
    checks++; if (c3_led !== 3'b001 || c3_busy !== 3'b000) begin errors++; $display("FAIL oor_ignore led=%b busy=%b exp=001/000", c3_led, c3_busy); end
  endtask
  task automatic test_reset_mid();
    cfg(2'd0, 3'd3, 8'd2);
    step(3);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy[0]); end
    cfg_chan = 2'd0;
    @(negedge clk) reset_ = 1'b0;
    #1;
    checks++; if (led !== 4'b0 || busy !== 4'b0) begin errors++; $display("FAIL mid_reset led=%b busy=%b exp=0000/0000", led, busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", cfg_ready); end
    #2 reset_ = 1'b1;
    step(10);
    checks++; if (led !== 4'b0 || busy !== 4'b0) begin errors++; $display("FAIL post_reset led=%b busy=%b exp=0000/0000", led, busy); end
  endtask
`ifdef LED_BREATHE_EN
  task automatic test_breathe();
    int highs;
    highs = 0;
    align();
    cfg(2'd1, 3'd4, 8'd0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (led[1] !== 1'b0) begin errors++; $display("FAIL breathe_duty0_k%0d got=%b exp=0", k, led[1]); end
      step(1);
    end
    for (int k = 0; k < 1200; k++) begin
      if (led[1]) highs++;
      step(1);
    end
    checks++; if (highs == 0) begin errors++; $display("FAIL breathe_ramp highs=%0d exp>0", highs); end
  endtask
`endif
  initial begin
    test_reset();
    test_on_blink();
    test_burst();
    test_off_cases();
    test_reset_mid();
`ifdef LED_BREATHE_EN
    test_breathe();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
